irq_controller: RTL



---
 rtl/irq_pkg.sv | 38 +++
 rtl/irq_if.sv | 28 ++
 rtl/irq_prio_enc.sv | 27 ++
 rtl/irq_controller.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
`default_nettype none
// ============================================================================
// Module : irq_pkg
// Brief  : Shared constants, state encoding and vector helper for irq_controller
// Rev    : 1.0
// ============================================================================
package irq_pkg;

    localparam logic [1:0] IRQ_IE  = 2'd0;
    localparam logic [1:0] IRQ_IP  = 2'd1;
    localparam logic [1:0] IRQ_ACT = 2'd2;
    localparam logic [1:0] IRQ_SWI = 2'd3;

    localparam logic [7:0] ACT_NONE = 8'hFF;

    localparam int SRC_UART_RX = 0;
    localparam int SRC_UART_TX = 1;
    localparam int SRC_TIMER   = 2;
    localparam int SRC_TIMER1  = 3;
    localparam int SRC_ENC     = 4;
    localparam int SRC_ENC1    = 5;
    localparam int SRC_SONAR   = 6;
    localparam int SRC_SW      = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        GAP  = 2'd2
    } irq_state_t;

    function automatic logic [15:0] vec_addr(input logic [15:0] base,
                                             input logic [15:0] stride,
                                             input logic [2:0]  idx);
        return base + (stride * {13'd0, idx});
    endfunction

endpackage
`default_nettype wire

// File: rtl/irq_if.sv
`default_nettype none
// ============================================================================
// Module : irq_if
// Brief  : CPU-side register bus and interrupt handshake of the irq controller
// Rev    : 1.0
// ============================================================================
interface irq_if;
    logic        sel;
    logic [1:0]  addr;
    logic [7:0]  din;
    logic        w_en;
    logic        r_en;
    logic [7:0]  dout;
    logic        interrupt;
    logic [15:0] intVect;
    logic        intAck;

    modport master (
        output sel, addr, din, w_en, r_en, intAck,
        input  dout, interrupt, intVect
    );

    modport slave (
        input  sel, addr, din, w_en, r_en, intAck,
        output dout, interrupt, intVect
    );
endinterface
`default_nettype wire

// File: rtl/irq_prio_enc.sv
`default_nettype none
// ============================================================================
// Module : irq_prio_enc
// Brief  : Combinational lowest-index-wins priority encoder
// Rev    : 1.0
// ============================================================================
module irq_prio_enc #(
    parameter int N = 8
) (
    input  wire logic [N-1:0] req,
    output logic              valid,
    output logic [2:0]        idx
);

    always_comb begin
        valid = |req;
        idx   = 3'd0;
        // Scan downward so the lowest set bit is the last assignment.
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = 3'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/irq_controller.sv
`default_nettype none
// ============================================================================
// Module : irq_controller
// Brief  : Memory-mapped 8-source interrupt controller with fixed priority
// Rev    : 1.0
// ============================================================================
module irq_controller
    import irq_pkg::*;
#(
    parameter int          N_SRC      = 8,
    parameter logic [15:0] VEC_BASE   = 16'h0010,
    parameter logic [15:0] VEC_STRIDE = 16'h0004
) (
    input  wire logic             clk,
    input  wire logic             rst,
    irq_if.slave                  bus,
    input  wire logic [N_SRC-1:0] src
);

    localparam logic [7:0] c_src_mask = 8'((16'd1 << N_SRC) - 16'd1);

    irq_state_t       r_state;
    irq_state_t       w_state_next;
    logic [7:0]       r_ie;
    logic [7:0]       r_ip;
    logic [7:0]       r_act;
    logic [N_SRC-1:0] r_src_q;
    logic [2:0]       r_win;
    logic             r_interrupt;
    logic [15:0]      r_vect;
    logic [7:0]       r_dout;

    logic [7:0]       w_rise;
    logic             w_wr;
    logic             w_rd;
    logic [7:0]       w_swi_set;
    logic [7:0]       w_w1c;
    logic             w_ack;
    logic [7:0]       w_ip_next;
    logic [7:0]       w_cand;
    logic             w_enc_valid;
    logic [2:0]       w_enc_idx;
    logic [2:0]       w_win_next;
    logic             w_int_next;
    logic [15:0]      w_vect_next;
    logic [7:0]       w_act_next;
    logic [7:0]       w_rdata;

    generate
        if (N_SRC == 8) begin : g_rise_full
            assign w_rise = src & ~r_src_q;
        end else begin : g_rise_part
            assign w_rise = {{(8 - N_SRC){1'b0}}, src & ~r_src_q};
        end
    endgenerate

    assign w_wr      = bus.sel & bus.w_en;
    assign w_rd      = bus.sel & bus.r_en;
    assign w_swi_set = (w_wr && bus.addr == IRQ_SWI) ? (bus.din & c_src_mask) : 8'd0;
    assign w_w1c     = (w_wr && bus.addr == IRQ_IP)  ? (bus.din & c_src_mask) : 8'd0;
    assign w_ack     = (r_state == REQ) & bus.intAck;
    assign w_cand    = r_ip & r_ie;

    // Sets win over a W1C clear; the acknowledge clear wins over everything
    // because it retires the very event being serviced.
    always_comb begin
        w_ip_next = ((r_ip & ~w_w1c) | w_rise | w_swi_set) & c_src_mask;
        if (w_ack) begin
            w_ip_next[r_win] = 1'b0;
        end
    end

    irq_prio_enc #(
        .N (N_SRC)
    ) u_prio_enc (
        .req   (w_cand[N_SRC-1:0]),
        .valid (w_enc_valid),
        .idx   (w_enc_idx)
    );

    always_comb begin
        w_state_next = r_state;
        w_int_next   = r_interrupt;
        w_vect_next  = r_vect;
        w_win_next   = r_win;
        w_act_next   = r_act;
        case (r_state)
            IDLE: begin
                w_int_next = 1'b0;
                if (w_enc_valid) begin
                    w_win_next   = w_enc_idx;
                    w_vect_next  = vec_addr(VEC_BASE, VEC_STRIDE, w_enc_idx);
                    w_int_next   = 1'b1;
                    w_state_next = REQ;
                end
            end
            REQ: begin
                // Committed: held until acked even if IP/IE are cleared meanwhile.
                w_int_next = 1'b1;
                if (bus.intAck) begin
                    w_int_next   = 1'b0;
                    w_act_next   = {5'd0, r_win};
                    w_state_next = GAP;
                end
            end
            GAP: begin
                w_int_next   = 1'b0;
                w_state_next = IDLE;
            end
            default: begin
                w_int_next   = 1'b0;
                w_state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        w_rdata = 8'd0;
        case (bus.addr)
            IRQ_IE:  w_rdata = r_ie;
            IRQ_IP:  w_rdata = r_ip;
            IRQ_ACT: w_rdata = r_act;
            default: w_rdata = 8'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_ie        <= 8'd0;
            r_ip        <= 8'd0;
            r_act       <= ACT_NONE;
            r_src_q     <= '0;
            r_win       <= 3'd0;
            r_interrupt <= 1'b0;
            r_vect      <= VEC_BASE;
            r_dout      <= 8'd0;
        end else begin
            r_state     <= w_state_next;
            r_ip        <= w_ip_next;
            r_act       <= w_act_next;
            r_src_q     <= src;
            r_win       <= w_win_next;
            r_interrupt <= w_int_next;
            r_vect      <= w_vect_next;
            if (w_wr && bus.addr == IRQ_IE) begin
                r_ie <= bus.din & c_src_mask;
            end
            if (w_rd) begin
                r_dout <= w_rdata;
            end
        end
    end

    assign bus.dout      = r_dout;
    assign bus.interrupt = r_interrupt;
    assign bus.intVect   = r_vect;

endmodule
`default_nettype wire
